uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 receiver. It supports configurable data width, parity mode, stop-bit count and baud divider. Line sampling uses a 3-sample majority vote at mid-bit, and frames carry error reporting. Received words are buffered in a small output FIFO with a pop handshake, so the downstream logic does not have to service every frame within one byte time.

Parameters:
CLK_DIV, 5000, clocks per bit (min 8); 100 MHz clk gives 20 kbaud at the default
DATA_BITS, 8, data bits per frame, 5..9, LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, output buffer entries, power of 2, >= 2

Ports:
clk  in  1  system clock
res  in  1  asynchronous active-low reset
rx  in  1  serial line, idle high, asynchronous to clk
data_out  out  DATA_BITS  FIFO head word, valid while empty = 0
empty  out  1  FIFO empty
full  out  1  FIFO full
rd_en  in  1  pop FIFO head this cycle (ignored when empty)
frame_err  out  1  1-cycle pulse, stop bit sampled 0
parity_err  out  1  1-cycle pulse, parity mismatch
overrun  out  1  1-cycle pulse, good frame dropped because FIFO full

Behaviour:
- Reset (res = 0, async):
  - State IDLE; rx synchroniser flops = 1; bit and baud counters = 0.
  - FIFO empty: empty = 1, full = 0, data_out = 0.
  - All error pulses = 0.
- rx passes through a 2-FF synchroniser; all sampling uses the synchronised rx_s. Add 2 cycles to every latency below.
- Baud counter runs 0..CLK_DIV-1 within each bit.
  - Samples taken at counts M-1, M, M+1, where M = CLK_DIV/2.
  - Bit value = majority of the 3 samples, resolved at count M+1.
- FSM states IDLE, START, DATA, PAR, STOP:
  - IDLE: falling edge of rx_s (previous 1, now 0) -> START, counter = 0. A line held low does not retrigger.
  - START: at the mid-bit decision, majority 1 -> IDLE (false start, no pulse, nothing stored); majority 0 -> DATA at end of bit.
  - DATA: shift in DATA_BITS bits LSB first. After the last bit -> PAR if PARITY != 0, else STOP.
  - PAR: sampled bit is compared with the XOR of data bits (even) or its inverse (odd); mismatch latches a parity flag.
  - STOP: each stop bit is checked at the mid-bit decision.
    - Any 0 -> frame_err pulse, frame discarded, -> IDLE immediately.
    - On the final stop bit's decision cycle: parity flag set -> parity_err pulse, discard. Otherwise push the word, or pulse overrun if it cannot be pushed. Then -> IDLE.
    - The FSM does not wait out the second half of the stop bit, so back-to-back frames with minimum stop length are received.
  - frame_err takes priority: parity_err is not pulsed on a frame that also has a bad stop bit.
- FIFO:
  - Push is written at the decision clock edge. empty falls and data_out shows the word on the following cycle.
  - Pop on rd_en && !empty; the next word appears on data_out the cycle after.
  - Simultaneous push and pop when full: both happen, count unchanged, no overrun.
  - Simultaneous push and pop when empty: the push occurs, the pop is ignored.
  - Pointers wrap modulo FIFO_DEPTH; an extra occupancy bit distinguishes full from empty.
- Reset asserted mid-frame aborts the frame immediately. After release the FSM waits for a fresh falling edge.
- rx is only sampled; it never affects outputs combinationally.

Decomposition:
- Shared package/include uart_pkg holds:
  - FSM state encodings: IDLE = 0, START = 1, DATA = 2, PAR = 3, STOP = 4.
  - Parity mode constants: PAR_NONE, PAR_ODD, PAR_EVEN.
  - A function computing the parity bit.
- One sub-module, uart_rx_fifo: synchronous FIFO with parameters WIDTH and DEPTH, ports clk/res/wr_en/wr_data/rd_en/rd_data/empty/full.
- The receiver FSM, synchroniser, baud counter and majority vote live in uart_rx_param.

Test Plan:
1. Defaults (CLK_DIV = 5000, 8N1): drive a start bit, 8'hAA LSB first, then a stop bit -> empty falls 1 cycle after the stop-bit decision; data_out = 8'hAA; no error pulses; rd_en -> empty = 1.
2. CLK_DIV = 16, PARITY = 2: frame 8'h5A with parity 0 -> stored 8'h5A. The same frame with parity 1 -> parity_err single pulse, FIFO stays empty.
3. CLK_DIV = 16: 8'h3C with a stop bit of 0 -> frame_err pulse, nothing stored. Line then held low, then released, then a 8'h81 frame -> 8'h81 stored, no spurious frame in between.
4. CLK_DIV = 16, idle line: 3-clock low glitch -> false start, no pulse, empty stays 1. A 1-clock high glitch at a data bit's mid-sample is out-voted -> byte received intact.
5. FIFO_DEPTH = 4, no reads: 5 back-to-back frames 8'h01..8'h05 with STOP_BITS = 1 -> full = 1, overrun pulses on frame 5, pops return 01, 02, 03, 04. Also pop on the same cycle as a push while full -> no overrun.
6. DATA_BITS = 5, PARITY = 1, STOP_BITS = 2: send 5'h13 with a correct parity bit -> data_out = 5'h13. Assert res = 0 mid-data on a subsequent frame -> empty = 1 immediately; after release a new 5'h0A frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: FSM state encoding,
// parity mode constants and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Parity bit the transmitter should have sent for a zero-extended data word.
  function automatic logic parity_bit(input logic [15:0] data, input int mode);
    logic x;
    x = ^data;
    if (mode == PAR_ODD)  return ~x;
    if (mode == PAR_EVEN) return x;
    return 1'b0;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous output FIFO for received words; head word is shown on rd_data
// (forced to zero while empty), pointers carry one extra wrap bit.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_rd   = rd_en && !empty;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    do_wr   = wr_en && (!full || do_rd);
    rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-FF synchroniser, 3-sample mid-bit majority vote,
// parity and stop-bit checking, words buffered in a small output FIFO.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 5000,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = PAR_NONE,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 empty,
  output logic                 full,
  input  logic                 rd_en,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);
  localparam int CW  = $clog2(CLK_DIV);
  localparam int MID = CLK_DIV / 2;

  localparam logic [CW-1:0] CNT_S0  = CW'(MID - 1);
  localparam logic [CW-1:0] CNT_S1  = CW'(MID);
  localparam logic [CW-1:0] CNT_DEC = CW'(MID + 1);
  localparam logic [CW-1:0] CNT_END = CW'(CLK_DIV - 1);
  localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  rx_state_t            state;
  logic                 rx_p0;
  logic                 rx_s;
  logic                 rx_prev;
  logic [CW-1:0]        baud_cnt;
  logic [3:0]           bit_cnt;
  logic                 samp0;
  logic                 samp1;
  logic                 par_bad;
  logic [DATA_BITS-1:0] shreg;

  logic                 maj;
  logic                 at_dec;
  logic                 at_end;
  logic                 push;

  always_comb begin
    maj    = maj3(samp0, samp1, rx_s);
    at_dec = (baud_cnt == CNT_DEC);
    at_end = (baud_cnt == CNT_END);
    push   = 1'b0;
    if (state == STOP && at_dec && maj && bit_cnt == STOP_LAST && !par_bad && (!full || rd_en))
      push = 1'b1;
  end

  // Stage p0/p1: synchroniser; rx_prev feeds the falling-edge detector.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      rx_p0      <= 1'b1;
      rx_s       <= 1'b1;
      rx_prev    <= 1'b1;
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      samp0      <= 1'b1;
      samp1      <= 1'b1;
      par_bad    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_p0      <= rx;
      rx_s       <= rx_p0;
      rx_prev    <= rx_s;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;

      if (state != IDLE) begin
        baud_cnt <= at_end ? '0 : baud_cnt + CW'(1);
        if (baud_cnt == CNT_S0) samp0 <= rx_s;
        if (baud_cnt == CNT_S1) samp1 <= rx_s;
      end

      unique case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          par_bad  <= 1'b0;
          if (rx_prev && !rx_s) state <= START;
        end
        START: begin
          if (at_dec && maj) begin
            state <= IDLE;
          end else if (at_end) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (at_end) begin
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              state   <= (PARITY != PAR_NONE) ? PAR : STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        PAR: begin
          if (at_dec) par_bad <= (maj != parity_bit(16'(shreg), PARITY));
          if (at_end) state <= STOP;
        end
        STOP: begin
          // Leave at the final decision so a following start bit is not missed.
          if (at_dec) begin
            if (!maj) begin
              frame_err <= 1'b1;
              state     <= IDLE;
            end else if (bit_cnt == STOP_LAST) begin
              if (par_bad)             parity_err <= 1'b1;
              else if (full && !rd_en) overrun    <= 1'b1;
              state <= IDLE;
            end
          end else if (at_end) begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data shift register, LSB first: newest bit enters at the top.
  always_ff @(posedge clk) begin
    if (state == DATA && at_dec) shreg <= {maj, shreg[DATA_BITS-1:1]};
  end

  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .res     (res),
    .wr_en   (push),
    .wr_data (shreg),
    .rd_en   (rd_en),
    .rd_data (data_out),
    .empty   (empty),
    .full    (full)
  );

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: four instances cover default 8N1, even parity,
// 8N1 at a short divider (errors, glitches, FIFO) and 5-bit odd parity with 2 stops.
module tb_uart_rx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rx_v;
  logic [3:0] res_v;
  logic [3:0] rd_v;
  logic [3:0] empty_v;
  logic [3:0] full_v;
  logic [3:0] fe_v;
  logic [3:0] pe_v;
  logic [3:0] ov_v;
  logic [7:0] dout0;
  logic [7:0] dout1;
  logic [7:0] dout2;
  logic [4:0] dout3;

  int total = 0;
  int bad   = 0;
  int fe_cnt [4] = '{default: 0};
  int pe_cnt [4] = '{default: 0};
  int ov_cnt [4] = '{default: 0};

  uart_rx_param u_def (
    .clk(clk), .res(res_v[0]), .rx(rx_v[0]), .data_out(dout0), .empty(empty_v[0]),
    .full(full_v[0]), .rd_en(rd_v[0]), .frame_err(fe_v[0]), .parity_err(pe_v[0]),
    .overrun(ov_v[0])
  );

  uart_rx_param #(.CLK_DIV(16), .PARITY(2)) u_even (
    .clk(clk), .res(res_v[1]), .rx(rx_v[1]), .data_out(dout1), .empty(empty_v[1]),
    .full(full_v[1]), .rd_en(rd_v[1]), .frame_err(fe_v[1]), .parity_err(pe_v[1]),
    .overrun(ov_v[1])
  );

  uart_rx_param #(.CLK_DIV(16)) u_n81 (
    .clk(clk), .res(res_v[2]), .rx(rx_v[2]), .data_out(dout2), .empty(empty_v[2]),
    .full(full_v[2]), .rd_en(rd_v[2]), .frame_err(fe_v[2]), .parity_err(pe_v[2]),
    .overrun(ov_v[2])
  );

  uart_rx_param #(.CLK_DIV(16), .DATA_BITS(5), .PARITY(1), .STOP_BITS(2)) u_odd5 (
    .clk(clk), .res(res_v[3]), .rx(rx_v[3]), .data_out(dout3), .empty(empty_v[3]),
    .full(full_v[3]), .rd_en(rd_v[3]), .frame_err(fe_v[3]), .parity_err(pe_v[3]),
    .overrun(ov_v[3])
  );

  // Pulses last one cycle, so each one is counted once per negedge it is seen.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      fe_cnt[i] <= fe_cnt[i] + int'(fe_v[i]);
      pe_cnt[i] <= pe_cnt[i] + int'(pe_v[i]);
      ov_cnt[i] <= ov_cnt[i] + int'(ov_v[i]);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input int idx, input logic v, input int n);
    rx_v[idx] = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic pop(input int idx);
    rd_v[idx] = 1'b1;
    @(negedge clk);
    rd_v[idx] = 1'b0;
  endtask

  // Frame at 16 clocks/bit. pbit < 0 means no parity bit. ev_kind 1 flips rx for
  // one clock at (ev_bit, ev_c); ev_kind 2 raises rd_en for one clock there.
  task automatic send_frame(input int idx, input logic [8:0] data, input int nbits,
                            input int pbit, input logic stopv, input int nstop,
                            input int ev_bit, input int ev_c, input int ev_kind);
    logic [15:0] fr;
    int n;
    fr = '0;
    fr[0] = 1'b0;
    for (int i = 0; i < nbits; i++) fr[1+i] = data[i];
    n = 1 + nbits;
    if (pbit >= 0) begin
      fr[n] = pbit[0];
      n++;
    end
    for (int s = 0; s < nstop; s++) begin
      fr[n] = stopv;
      n++;
    end
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < 16; c++) begin
        rx_v[idx] = fr[b] ^ (ev_kind == 1 && b == ev_bit && c == ev_c);
        rd_v[idx] = (ev_kind == 2 && b == ev_bit && c == ev_c);
        @(negedge clk);
      end
    end
    rd_v[idx] = 1'b0;
  endtask

  task automatic test_default();
    logic [7:0] d;
    int n, f0, p0, o0;
    d  = 8'hAA;
    f0 = fe_cnt[0];
    p0 = pe_cnt[0];
    o0 = ov_cnt[0];
    drive_bit(0, 1'b0, 5000);
    for (int i = 0; i < 8; i++) drive_bit(0, d[i], 5000);
    rx_v[0] = 1'b1;
    n = 0;
    while (empty_v[0] && n < 5000) begin
      @(negedge clk);
      n++;
    end
    // Word visible M+5 clocks into the stop bit: 2 sync + edge detect + decision + write.
    chk("t1_latency", n, 5000 / 2 + 5);
    chk("t1_data", dout0, 8'hAA);
    repeat (2600) @(negedge clk);
    chk("t1_fe", fe_cnt[0] - f0, 0);
    chk("t1_pe", pe_cnt[0] - p0, 0);
    chk("t1_ov", ov_cnt[0] - o0, 0);
    pop(0);
    chk("t1_pop_empty", empty_v[0], 1);
  endtask

  task automatic test_parity();
    int f0, p0;
    f0 = fe_cnt[1];
    p0 = pe_cnt[1];
    send_frame(1, 9'h05A, 8, 0, 1'b1, 1, -1, 0, 0);
    repeat (4) @(negedge clk);
    chk("t2_empty", empty_v[1], 0);
    chk("t2_data", dout1, 8'h5A);
    chk("t2_pe_good", pe_cnt[1] - p0, 0);
    pop(1);
    chk("t2_pop_empty", empty_v[1], 1);
    send_frame(1, 9'h05A, 8, 1, 1'b1, 1, -1, 0, 0);
    repeat (4) @(negedge clk);
    chk("t2_pe_bad", pe_cnt[1] - p0, 1);
    chk("t2_bad_empty", empty_v[1], 1);
    chk("t2_fe", fe_cnt[1] - f0, 0);
  endtask

  task automatic test_frame();
    int f0;
    f0 = fe_cnt[2];
    send_frame(2, 9'h03C, 8, -1, 1'b0, 1, -1, 0, 0);
    drive_bit(2, 1'b0, 40);
    chk("t3_fe", fe_cnt[2] - f0, 1);
    chk("t3_empty", empty_v[2], 1);
    drive_bit(2, 1'b1, 32);
    send_frame(2, 9'h081, 8, -1, 1'b1, 1, -1, 0, 0);
    repeat (4) @(negedge clk);
    chk("t3_data", dout2, 8'h81);
    chk("t3_fe_once", fe_cnt[2] - f0, 1);
    pop(2);
    chk("t3_single_word", empty_v[2], 1);
  endtask

  task automatic test_glitch();
    int f0;
    f0 = fe_cnt[2];
    drive_bit(2, 1'b0, 3);
    drive_bit(2, 1'b1, 40);
    chk("t4_false_start", empty_v[2], 1);
    chk("t4_fe", fe_cnt[2] - f0, 0);
    // Data bit 1 of 0xA5 is 0; the glitch lands on its middle sample.
    send_frame(2, 9'h0A5, 8, -1, 1'b1, 1, 2, 9, 1);
    repeat (4) @(negedge clk);
    chk("t4_voted", dout2, 8'hA5);
    pop(2);
    chk("t4_empty", empty_v[2], 1);
  endtask

  task automatic test_fifo();
    int o0;
    o0 = ov_cnt[2];
    for (int i = 1; i <= 5; i++) send_frame(2, 9'(i), 8, -1, 1'b1, 1, -1, 0, 0);
    repeat (4) @(negedge clk);
    chk("t5_full", full_v[2], 1);
    chk("t5_overrun", ov_cnt[2] - o0, 1);
    for (int i = 1; i <= 4; i++) begin
      chk("t5_pop", dout2, i);
      pop(2);
    end
    chk("t5_drained", empty_v[2], 1);
    for (int i = 0; i < 4; i++) send_frame(2, 9'(16 + i), 8, -1, 1'b1, 1, -1, 0, 0);
    repeat (4) @(negedge clk);
    chk("t5_refull", full_v[2], 1);
    // rd_en high on the stop-bit decision cycle of frame 0x14.
    send_frame(2, 9'h014, 8, -1, 1'b1, 1, 9, 12, 2);
    repeat (4) @(negedge clk);
    chk("t5_pp_overrun", ov_cnt[2] - o0, 1);
    chk("t5_pp_full", full_v[2], 1);
    for (int i = 0; i < 4; i++) begin
      chk("t5_pp_pop", dout2, 8'h11 + i);
      pop(2);
    end
    chk("t5_pp_empty", empty_v[2], 1);
  endtask

  task automatic test_odd5();
    int f0, p0;
    f0 = fe_cnt[3];
    p0 = pe_cnt[3];
    send_frame(3, 9'h013, 5, 0, 1'b1, 2, -1, 0, 0);
    repeat (4) @(negedge clk);
    chk("t6_empty", empty_v[3], 0);
    chk("t6_data", dout3, 5'h13);
    drive_bit(3, 1'b0, 16);
    drive_bit(3, 1'b1, 16);
    drive_bit(3, 1'b0, 8);
    res_v[3] = 1'b0;
    #1;
    chk("t6_rst_empty", empty_v[3], 1);
    chk("t6_rst_data", dout3, 0);
    repeat (3) @(negedge clk);
    rx_v[3] = 1'b1;
    repeat (2) @(negedge clk);
    res_v[3] = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6_after_rst", empty_v[3], 1);
    send_frame(3, 9'h00A, 5, 1, 1'b1, 2, -1, 0, 0);
    repeat (4) @(negedge clk);
    chk("t6_data2", dout3, 5'h0A);
    chk("t6_pe", pe_cnt[3] - p0, 0);
    chk("t6_fe", fe_cnt[3] - f0, 0);
  endtask

  initial begin
    rx_v  = '1;
    res_v = '0;
    rd_v  = '0;
    repeat (3) @(negedge clk);
    chk("rst_empty", empty_v, 4'hF);
    chk("rst_full", full_v, 0);
    chk("rst_data0", dout0, 0);
    chk("rst_data3", dout3, 0);
    chk("rst_pulses", {fe_v, pe_v, ov_v}, 0);
    res_v = '1;
    repeat (4) @(negedge clk);
    fork
      test_default();
      begin
        test_parity();
        test_frame();
        test_glitch();
        test_fifo();
        test_odd5();
      end
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
